dcache_data_arbiter: RTL and testbench

Single-owner controller for the 32×256-bit data cache SRAM (one RW port, byte write mask, inputs registered on clock edge, read data valid the cycle after issue). It arbitrates four requesters (line refill, victim writeback read, store-commit write, load read) onto the one port, one access per cycle. It drives the SRAM control pins and returns tagged read data one cycle after grant. An age counter stops loads from starving stores indefinitely.

---
 rtl/dcache_pkg.sv | 20 ++
 rtl/dcache_store_age_ctr.sv | 40 ++++
 rtl/dcache_data_arbiter.sv | 109 ++++++++++
 tb/tb_dcache_data_arbiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared types and sizing for the data cache SRAM arbiter.
//   rsp_src_t         : which read requester owns the data returning next cycle
//   DCACHE_SET_W      : set index width
//   DCACHE_LINE_W     : line width in bits
//   DCACHE_WMASK_W    : byte-enable count per line
//   DCACHE_ST_AGE_MAX : default wait (cycles) before a pending store outranks loads
package dcache_pkg;

   localparam int DCACHE_SET_W      = 5;
   localparam int DCACHE_LINE_W     = 256;
   localparam int DCACHE_WMASK_W    = DCACHE_LINE_W / 8;
   localparam int DCACHE_ST_AGE_MAX = 8;

   typedef enum logic [1:0] {
      RSP_NONE = 2'd0,
      RSP_LD   = 2'd1,
      RSP_WB   = 2'd2
   } rsp_src_t;

endpackage

// File: rtl/dcache_store_age_ctr.sv
// Saturating wait counter for the store-commit requester.
//   clk, rst : clock, async active-high reset
//   pending  : store request is being held
//   granted  : store was accepted this cycle
//   aged     : store has waited ST_AGE_MAX cycles and now outranks loads
module dcache_store_age_ctr
   import dcache_pkg::*;
#(
   parameter int ST_AGE_MAX = DCACHE_ST_AGE_MAX
) (
   input  logic clk,
   input  logic rst,
   input  logic pending,
   input  logic granted,
   output logic aged
);

   localparam int AGE_W = $clog2(ST_AGE_MAX + 1);
   localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(ST_AGE_MAX);

   logic [AGE_W-1:0] age_d, age_q;

   always_comb begin
      age_d = age_q;
      if (!pending || granted) begin
         age_d = '0;
      end else if (age_q != AGE_MAX) begin
         age_d = age_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) age_q <= '0;
      else     age_q <= age_d;
   end

   // Driven purely from the register, so no loop through the grant logic.
   assign aged = (age_q == AGE_MAX);

endmodule

// File: rtl/dcache_data_arbiter.sv
// Single-owner arbiter for the one-port data cache SRAM.
// Four requesters (fill write, victim wb read, store write, load read) share
// the port with fixed priority fill > wb > aged store > load > store.
// Grants are combinational; read data returns one cycle after grant, tagged by
// ld_rvalid / wb_rvalid. SRAM control pins are driven straight from the winner.
//   fill_* : full-line refill write      wb_* : victim line read
//   st_*   : byte-masked store write     ld_* : load line read
//   sram_* : active-low csb/web, byte wmask, addr, din; sram_dout read data
module dcache_data_arbiter
   import dcache_pkg::*;
#(
   parameter int ADDR_WIDTH = DCACHE_SET_W,
   parameter int DATA_WIDTH = DCACHE_LINE_W,
   parameter int NUM_WMASKS = DCACHE_WMASK_W,
   parameter int ST_AGE_MAX = DCACHE_ST_AGE_MAX
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  fill_req,
   input  logic [ADDR_WIDTH-1:0] fill_addr,
   input  logic [DATA_WIDTH-1:0] fill_wdata,
   output logic                  fill_gnt,
   input  logic                  wb_req,
   input  logic [ADDR_WIDTH-1:0] wb_addr,
   output logic                  wb_gnt,
   output logic                  wb_rvalid,
   output logic [DATA_WIDTH-1:0] wb_rdata,
   input  logic                  st_req,
   input  logic [ADDR_WIDTH-1:0] st_addr,
   input  logic [NUM_WMASKS-1:0] st_wmask,
   input  logic [DATA_WIDTH-1:0] st_wdata,
   output logic                  st_gnt,
   input  logic                  ld_req,
   input  logic [ADDR_WIDTH-1:0] ld_addr,
   output logic                  ld_gnt,
   output logic                  ld_rvalid,
   output logic [DATA_WIDTH-1:0] ld_rdata,
   output logic                  sram_csb,
   output logic                  sram_web,
   output logic [NUM_WMASKS-1:0] sram_wmask,
   output logic [ADDR_WIDTH-1:0] sram_addr,
   output logic [DATA_WIDTH-1:0] sram_din,
   input  logic [DATA_WIDTH-1:0] sram_dout
);

   logic     st_aged;
   rsp_src_t rsp_d, rsp_q;

   dcache_store_age_ctr #(.ST_AGE_MAX(ST_AGE_MAX)) u_st_age (
      .clk     (clk),
      .rst     (rst),
      .pending (st_req),
      .granted (st_gnt),
      .aged    (st_aged)
   );

   always_comb begin
      fill_gnt   = 1'b0;
      wb_gnt     = 1'b0;
      st_gnt     = 1'b0;
      ld_gnt     = 1'b0;
      if      (fill_req)           fill_gnt = 1'b1;
      else if (wb_req)             wb_gnt   = 1'b1;
      else if (st_req && st_aged)  st_gnt   = 1'b1;
      else if (ld_req)             ld_gnt   = 1'b1;
      else if (st_req)             st_gnt   = 1'b1;

      sram_csb   = 1'b1;
      sram_web   = 1'b1;
      sram_wmask = '0;
      sram_addr  = '0;
      sram_din   = '0;
      if (fill_gnt) begin
         sram_csb   = 1'b0;
         sram_web   = 1'b0;
         sram_wmask = '1;
         sram_addr  = fill_addr;
         sram_din   = fill_wdata;
      end else if (wb_gnt) begin
         sram_csb   = 1'b0;
         sram_addr  = wb_addr;
      end else if (st_gnt) begin
         sram_csb   = 1'b0;
         sram_web   = 1'b0;
         sram_wmask = st_wmask;
         sram_addr  = st_addr;
         sram_din   = st_wdata;
      end else if (ld_gnt) begin
         sram_csb   = 1'b0;
         sram_addr  = ld_addr;
      end

      rsp_d = RSP_NONE;
      if      (ld_gnt) rsp_d = RSP_LD;
      else if (wb_gnt) rsp_d = RSP_WB;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) rsp_q <= RSP_NONE;
      else     rsp_q <= rsp_d;
   end

   assign ld_rvalid = (rsp_q == RSP_LD);
   assign wb_rvalid = (rsp_q == RSP_WB);
   // Both read ports see the SRAM output; rvalid says whose it is.
   assign ld_rdata  = sram_dout;
   assign wb_rdata  = sram_dout;

endmodule

// File: tb/tb_dcache_data_arbiter.sv
// Bench for dcache_data_arbiter: behavioural SRAM fixture, directed scenarios
// and a randomized phase, all checked against a request-level reference model.
module tb_dcache_data_arbiter;
   localparam int AW = 5;
   localparam int DW = 256;
   localparam int MW = 32;
   localparam int AGE = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          fill_req = 0, wb_req = 0, st_req = 0, ld_req = 0;
   logic [AW-1:0] fill_addr = 0, wb_addr = 0, st_addr = 0, ld_addr = 0;
   logic [DW-1:0] fill_wdata = 0, st_wdata = 0;
   logic [MW-1:0] st_wmask = 0;
   logic          fill_gnt, wb_gnt, st_gnt, ld_gnt, wb_rvalid, ld_rvalid;
   logic [DW-1:0] wb_rdata, ld_rdata;
   logic          sram_csb, sram_web;
   logic [MW-1:0] sram_wmask;
   logic [AW-1:0] sram_addr;
   logic [DW-1:0] sram_din, sram_dout;

   dcache_data_arbiter dut (
      .clk(clk), .rst(rst),
      .fill_req(fill_req), .fill_addr(fill_addr), .fill_wdata(fill_wdata), .fill_gnt(fill_gnt),
      .wb_req(wb_req), .wb_addr(wb_addr), .wb_gnt(wb_gnt), .wb_rvalid(wb_rvalid), .wb_rdata(wb_rdata),
      .st_req(st_req), .st_addr(st_addr), .st_wmask(st_wmask), .st_wdata(st_wdata), .st_gnt(st_gnt),
      .ld_req(ld_req), .ld_addr(ld_addr), .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
      .sram_csb(sram_csb), .sram_web(sram_web), .sram_wmask(sram_wmask),
      .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout)
   );

   always #5 clk = ~clk;

   // SRAM fixture: inputs sampled on the edge, registered read data.
   logic [DW-1:0] mem [32];
   always @(posedge clk) begin
      if (!sram_csb) begin
         if (!sram_web) begin
            for (int b = 0; b < MW; b++)
               if (sram_wmask[b]) mem[sram_addr][b*8 +: 8] <= sram_din[b*8 +: 8];
         end else begin
            sram_dout <= mem[sram_addr];
         end
      end
   end

   int n_chk = 0, n_err = 0;

   task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Reference model state
   logic [DW-1:0] ref_mem [32];
   int            m_age = 0;
   logic          exp_ld_v = 0, exp_wb_v = 0;
   logic [DW-1:0] exp_rd = 0;
   int            obs_win;
   logic          obs_web;

   function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                           input logic [MW-1:0] m);
      logic [DW-1:0] r = old;
      for (int b = 0; b < MW; b++) if (m[b]) r[b*8 +: 8] = nw[b*8 +: 8];
      return r;
   endfunction

   function automatic logic [DW-1:0] rand_line();
      logic [DW-1:0] v;
      for (int i = 0; i < DW/32; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   // One cycle: check DUT against the model, then advance the model.
   // Winner codes: 0 none, 1 fill, 2 wb, 3 store, 4 load.
   task automatic step();
      int            mw;
      logic [AW-1:0] ea;
      logic [MW-1:0] em;
      logic [DW-1:0] ed;
      @(negedge clk);
      if (fill_req)                      mw = 1;
      else if (wb_req)                   mw = 2;
      else if (st_req && m_age >= AGE)   mw = 3;
      else if (ld_req)                   mw = 4;
      else if (st_req)                   mw = 3;
      else                               mw = 0;
      obs_win = fill_gnt ? 1 : wb_gnt ? 2 : st_gnt ? 3 : ld_gnt ? 4 : 0;
      obs_web = sram_web;
      case (mw)
         1:       begin ea = fill_addr; em = '1;       ed = fill_wdata; end
         2:       begin ea = wb_addr;   em = '0;       ed = '0;         end
         3:       begin ea = st_addr;   em = st_wmask; ed = st_wdata;   end
         4:       begin ea = ld_addr;   em = '0;       ed = '0;         end
         default: begin ea = '0;        em = '0;       ed = '0;         end
      endcase
      chk("fill_gnt", fill_gnt, mw == 1);
      chk("wb_gnt",   wb_gnt,   mw == 2);
      chk("st_gnt",   st_gnt,   mw == 3);
      chk("ld_gnt",   ld_gnt,   mw == 4);
      chk("sram_csb", sram_csb, mw == 0);
      chk("sram_web", sram_web, !(mw == 1 || mw == 3));
      chk("sram_addr", sram_addr, ea);
      chk("sram_wmask", sram_wmask, em);
      if (mw != 2 && mw != 4) chk("sram_din", sram_din, ed);
      chk("ld_rvalid", ld_rvalid, exp_ld_v);
      chk("wb_rvalid", wb_rvalid, exp_wb_v);
      if (exp_ld_v) chk("ld_rdata", ld_rdata, exp_rd);
      if (exp_wb_v) chk("wb_rdata", wb_rdata, exp_rd);

      exp_ld_v = (mw == 4);
      exp_wb_v = (mw == 2);
      if (mw == 2 || mw == 4) exp_rd = ref_mem[ea];
      if (mw == 1 || mw == 3) ref_mem[ea] = merge(ref_mem[ea], ed, em);
      if (st_req && mw != 3) m_age = (m_age < AGE) ? m_age + 1 : AGE;
      else                   m_age = 0;
      @(posedge clk); #1;
      case (mw)
         1: fill_req = 0;
         2: wb_req   = 0;
         3: st_req   = 0;
         4: ld_req   = 0;
         default: ;
      endcase
   endtask

   initial begin
      int            order [4];
      logic          webs  [4];
      int            st_cyc;
      logic [DW-1:0] sv;

      for (int i = 0; i < 32; i++) begin mem[i] = '0; ref_mem[i] = '0; end
      sram_dout = '0;

      // Reset state
      #2;
      chk("rst_fill_gnt", fill_gnt, 0);
      chk("rst_ld_rvalid", ld_rvalid, 0);
      chk("rst_wb_rvalid", wb_rvalid, 0);
      chk("rst_csb", sram_csb, 1);
      chk("rst_web", sram_web, 1);
      chk("rst_wmask", sram_wmask, 0);
      chk("rst_addr", sram_addr, 0);
      chk("rst_din", sram_din, 0);
      @(negedge clk); rst = 0;
      @(posedge clk); #1;

      // Fill set 3 with A5, then load it back
      fill_req = 1; fill_addr = 3; fill_wdata = {32{8'hA5}};
      step();
      ld_req = 1; ld_addr = 3;
      step();
      chk("single_ld_rvalid", ld_rvalid, 1);
      chk("single_ld_rdata", ld_rdata, {32{8'hA5}});
      chk("single_wb_rvalid", wb_rvalid, 0);
      step();

      // All four at once
      fill_req = 1; fill_addr = 1; fill_wdata = rand_line();
      wb_req = 1;   wb_addr = 2;
      st_req = 1;   st_addr = 4; st_wmask = '1; st_wdata = rand_line();
      ld_req = 1;   ld_addr = 5;
      for (int i = 0; i < 4; i++) begin step(); order[i] = obs_win; webs[i] = obs_web; end
      chk("order0", order[0], 1); chk("order1", order[1], 2);
      chk("order2", order[2], 4); chk("order3", order[3], 3);
      chk("web0", webs[0], 0); chk("web1", webs[1], 1);
      chk("web2", webs[2], 1); chk("web3", webs[3], 0);
      step();

      // Masked store into a line of 0x11
      fill_req = 1; fill_addr = 9; fill_wdata = {32{8'h11}};
      step();
      sv = rand_line(); sv[7:0] = 8'h5C;
      st_req = 1; st_addr = 9; st_wmask = 32'h0000_0001; st_wdata = sv;
      step();
      ld_req = 1; ld_addr = 9;
      step();
      sv = {32{8'h11}}; sv[7:0] = 8'h5C;
      chk("mask_ld_rdata", ld_rdata, sv);
      step();

      // Starvation: loads held continuously, store must win on cycle AGE; twice
      for (int r = 0; r < 2; r++) begin
         st_req = 1; st_addr = 5'(10 + r); st_wmask = '1; st_wdata = rand_line();
         ld_req = 1; ld_addr = 5'($urandom_range(0, 31));
         st_cyc = -1;
         for (int c = 0; c < 20 && st_cyc < 0; c++) begin
            step();
            if (obs_win == 3) st_cyc = c;
            if (!ld_req) begin ld_req = 1; ld_addr = 5'($urandom_range(0, 31)); end
         end
         chk("starve_cycle", st_cyc, AGE);
         for (int c = 0; c < 2; c++) step();
         ld_req = 0;
         step();
      end

      // RAW on set 7
      sv = rand_line();
      st_req = 1; st_addr = 7; st_wmask = '1; st_wdata = sv;
      step();
      ld_req = 1; ld_addr = 7;
      step();
      chk("raw_ld_rvalid", ld_rvalid, 1);
      chk("raw_ld_rdata", ld_rdata, sv);
      step();

      // Async reset the cycle after a load grant
      ld_req = 1; ld_addr = 3;
      step();
      rst = 1; #1;
      chk("arst_ld_rvalid", ld_rvalid, 0);
      chk("arst_csb", sram_csb, 1);
      exp_ld_v = 0; exp_wb_v = 0; m_age = 0;
      @(negedge clk); rst = 0;
      @(posedge clk); #1;
      for (int c = 0; c < 3; c++) step();

      // Randomized traffic
      for (int c = 0; c < 400; c++) begin
         if (!fill_req && $urandom_range(0, 9) == 0) begin
            fill_req = 1; fill_addr = 5'($urandom_range(0, 31)); fill_wdata = rand_line();
         end
         if (!wb_req && $urandom_range(0, 5) == 0) begin
            wb_req = 1; wb_addr = 5'($urandom_range(0, 31));
         end
         if (!st_req && $urandom_range(0, 2) == 0) begin
            st_req = 1; st_addr = 5'($urandom_range(0, 31));
            st_wmask = $urandom; st_wdata = rand_line();
         end
         if (!ld_req && $urandom_range(0, 3) != 0) begin
            ld_req = 1; ld_addr = 5'($urandom_range(0, 31));
         end
         step();
      end
      fill_req = 0; wb_req = 0; st_req = 0; ld_req = 0;
      step();
      step();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1);
   end
endmodule
